// File: rtl/pipe_ifu.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests under a
// credit limit, tags responses with their PC and buffers them for decode.
module pipe_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_data_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        if_valid_o,
  input  logic        id_ready_i,
  output logic [63:0] ifToId_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  localparam logic [0:0] BOOT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0]   tag_q [DEPTH];
  logic [PW-1:0] tag_wr_q, tag_rd_q;
  logic [63:0]   buf_q [DEPTH];
  logic [PW-1:0] buf_wr_q, buf_rd_q;

  logic [CW:0]   occupancy;
  logic          credit;
  logic          accept;
  logic          keep;
  logic          pop;

  assign occupancy        = {1'b0, inflight_q} + {1'b0, cnt_q};
  assign credit           = occupancy < DEPTH_W;
  assign imem_req_valid_o = (state_q == RUN) && credit && !redirect_valid_i;
  assign imem_req_addr_o  = {pc_q[31:2], 2'b00};
  assign accept           = imem_req_valid_o && imem_req_ready_i;
  assign keep             = imem_resp_valid_i && (drop_q == '0) && !redirect_valid_i;
  assign pop              = (cnt_q != '0) && id_ready_i && !redirect_valid_i;

  assign if_valid_o = (cnt_q != '0);
  assign ifToId_o   = buf_q[buf_rd_q];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = inflight_q + CW'(accept) - CW'(imem_resp_valid_i);
    drop_d     = drop_q;
    cnt_d      = cnt_q + CW'(keep) - CW'(pop);

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase

    if (redirect_valid_i) begin
      pc_d  = redirect_pc_i & ~32'h3;
      cnt_d = '0;
      // inflight already includes earlier stale requests, so every outstanding
      // request becomes stale except the one whose response lands right now.
      drop_d = inflight_q - CW'(imem_resp_valid_i);
    end else begin
      if (accept) pc_d = pc_q + 32'd4;
      if (imem_resp_valid_i && (drop_q != '0)) drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      buf_wr_q   <= '0;
      buf_rd_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      if (accept)            tag_wr_q <= tag_wr_q + 1'b1;
      if (imem_resp_valid_i) tag_rd_q <= tag_rd_q + 1'b1;
      if (redirect_valid_i) begin
        buf_wr_q <= '0;
        buf_rd_q <= '0;
      end else begin
        if (keep) begin
          buf_q[buf_wr_q] <= {tag_q[tag_rd_q], imem_resp_data_i};
          buf_wr_q        <= buf_wr_q + 1'b1;
        end
        if (pop) buf_rd_q <= buf_rd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) tag_q[tag_wr_q] <= pc_q;
  end

  resp_has_tag: assert property (@(posedge clk_i) disable iff (!rst_ni)
    imem_resp_valid_i |-> (inflight_q != '0));

endmodule
